// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer.
// Holds the op_type encodings, the fault codes, the sequencer state enum
// and the default width and stack-depth parameters.
package pc_seq_pkg;

    localparam int unsigned PC_W_DEF  = 19;
    localparam int unsigned DEPTH_DEF = 56;

    typedef enum logic [1:0] {
        OP_SEQ  = 2'b00,
        OP_JMP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        FC_NONE      = 2'b00,
        FC_OVERFLOW  = 2'b01,
        FC_UNDERFLOW = 2'b10
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SETTLE,
        ST_FAULT
    } state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer, upstream of the return-address stack.
// Accepts one control-flow op per cycle (seq/jump/call/ret), drives the
// stack's call/ret strobes and return address, reloads the PC from
// top-of-stack on return, and tracks occupancy so that overflow/underflow
// become a sticky fault rather than a corrupted stack.
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   stall             freeze: no op accepted, all state held
//   op_valid/op_type  op presented this cycle (00 seq, 01 jump, 10 call, 11 ret)
//   target            jump/call destination
//   tos_data          combinational top-of-stack read from the stack
//   pc, pc_valid      current PC and whether it is fetchable this cycle
//   call, push_data   one-cycle push strobe and the return address to write
//   ret               one-cycle pop strobe
//   depth             entries currently on the stack
//   fault, fault_code sticky fault flag and its cause (01 overflow, 10 underflow)
//   clr_fault         clears the fault; only honoured while faulted
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter int unsigned     DEPTH    = DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            op_valid,
    input  logic [1:0]      op_type,
    input  logic [PC_W-1:0] target,
    input  logic [PC_W-1:0] tos_data,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            call,
    output logic [PC_W-1:0] push_data,
    output logic            ret,
    output logic [7:0]      depth,
    output logic            fault,
    output logic [1:0]      fault_code,
    input  logic            clr_fault
);

    localparam logic [7:0] DEPTH_MAX = 8'(DEPTH);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            call_q, call_d;
    logic            ret_q, ret_d;
    logic [PC_W-1:0] push_data_q, push_data_d;
    logic [7:0]      depth_q, depth_d;
    logic            fault_q, fault_d;
    fault_code_e     fault_code_q, fault_code_d;

    logic [PC_W-1:0] pc_inc;

    // Natural truncation gives the all-ones -> zero wrap.
    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        push_data_d  = push_data_q;
        depth_d      = depth_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        call_d       = 1'b0;
        ret_d        = 1'b0;

        if (!stall) begin
            unique case (state_q)
                ST_RUN: begin
                    if (op_valid) begin
                        case (op_e'(op_type))
                            OP_SEQ: pc_d = pc_inc;
                            OP_JMP: pc_d = target;
                            OP_CALL: begin
                                if (depth_q < DEPTH_MAX) begin
                                    push_data_d = pc_inc;
                                    call_d      = 1'b1;
                                    pc_d        = target;
                                    depth_d     = depth_q + 8'd1;
                                    state_d     = ST_SETTLE;
                                end else begin
                                    fault_d      = 1'b1;
                                    fault_code_d = FC_OVERFLOW;
                                    state_d      = ST_FAULT;
                                end
                            end
                            OP_RET: begin
                                if (depth_q != '0) begin
                                    pc_d    = tos_data;
                                    ret_d   = 1'b1;
                                    depth_d = depth_q - 8'd1;
                                    state_d = ST_SETTLE;
                                end else begin
                                    fault_d      = 1'b1;
                                    fault_code_d = FC_UNDERFLOW;
                                    state_d      = ST_FAULT;
                                end
                            end
                        endcase
                    end
                end
                // One bubble while the stack pointer moves, so tos_data is
                // coherent again by the time RUN resumes.
                ST_SETTLE: state_d = ST_RUN;
                ST_FAULT: begin
                    if (clr_fault) begin
                        fault_d      = 1'b0;
                        fault_code_d = FC_NONE;
                        state_d      = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        // Registered: fetchable exactly when the next state is RUN.
        pc_valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            pc_valid_q   <= 1'b0;
            call_q       <= 1'b0;
            ret_q        <= 1'b0;
            push_data_q  <= '0;
            depth_q      <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            call_q       <= call_d;
            ret_q        <= ret_d;
            push_data_q  <= push_data_d;
            depth_q      <= depth_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = pc_valid_q;
    assign call       = call_q;
    assign ret        = ret_q;
    assign push_data  = push_data_q;
    assign depth      = depth_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule
